// File: rtl/sequencer_pkg.sv
// Shared command-word layout, opcode constants, FSM encoding and legality check
// for the memory write scheduler.
package sequencer_pkg;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_MEM    = 4'd1;
  localparam logic [3:0] OP_DOT    = 4'd2;
  localparam logic [3:0] OP_SEL    = 4'd3;
  localparam logic [3:0] OP_CONFIG = 4'd4;
  localparam logic [3:0] OP_MEM_BC = 4'd5;

  localparam int CMD_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  idx;
    logic [5:0]  addr;
    logic [1:0]  rsvd;
    logic [15:0] data;
  } cmd_t;

  // Per-driver opcodes are illegal when the index names a driver that does not exist.
  function automatic logic cmd_illegal(logic [3:0] op, logic [3:0] idx, int num_drivers);
    case (op)
      OP_NOP, OP_CONFIG, OP_MEM_BC: cmd_illegal = 1'b0;
      OP_MEM, OP_DOT, OP_SEL:       cmd_illegal = (int'(idx) >= num_drivers);
      default:                      cmd_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_write_scheduler_if.sv
// Command handshake plus the memory write bus (active-low strobes, address, data).
// The slave side is the scheduler; the master side feeds commands and observes writes.
interface mem_write_scheduler_if #(
  parameter int NUM_OF_DRIVERS     = 16,
  parameter int MEM_ADDRESS_LENGTH = 6
);
  logic                          cmd_valid;
  logic [31:0]                   cmd_data;
  logic                          cmd_ready;
  logic [NUM_OF_DRIVERS-1:0]     mem_write_n;
  logic [NUM_OF_DRIVERS-1:0]     mem_dot_write_n;
  logic [NUM_OF_DRIVERS-1:0]     mem_sel_write_n;
  logic                          write_config_n;
  logic [MEM_ADDRESS_LENGTH-1:0] wr_address;
  logic [15:0]                   wr_data;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, mem_write_n, mem_dot_write_n, mem_sel_write_n,
    input  write_config_n, wr_address, wr_data
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, mem_write_n, mem_dot_write_n, mem_sel_write_n,
    output write_config_n, wr_address, wr_data
  );
endinterface

// File: rtl/cmd_fifo.sv
// Show-ahead FIFO (head visible on rdata), zero-latency pop, push ignored when full.
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mem_write_scheduler.sv
// Buffers command words and replays each as a SETUP/STROBE/HOLD write outside the firing
// window; first strobe 2 cycles after acceptance, 1 write per 3 cycles, cmd_ready = !full.
module mem_write_scheduler
  import sequencer_pkg::*;
#(
  parameter int NUM_OF_DRIVERS     = 16,
  parameter int MEM_ADDRESS_LENGTH = 6,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_write_scheduler_if.slave  bus,
  input  logic                  cycle_active,
  input  logic                  err_clear,
  output logic                  busy,
  output logic                  illegal_cmd
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  cmd_t                          head;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [CW-1:0]                 fifo_count;
  logic                          push;
  logic                          launch;
  logic [NUM_OF_DRIVERS-1:0]     drv_sel_n;
  logic                          unused_bits;

  state_t                        state_q;
  logic                          rdy_q;
  logic [3:0]                    op_q;
  logic [3:0]                    idx_q;
  logic [MEM_ADDRESS_LENGTH-1:0] addr_q;
  logic [15:0]                   data_q;
  logic [NUM_OF_DRIVERS-1:0]     mem_wr_n_q;
  logic [NUM_OF_DRIVERS-1:0]     dot_wr_n_q;
  logic [NUM_OF_DRIVERS-1:0]     sel_wr_n_q;
  logic                          cfg_wr_n_q;
  logic                          illegal_q;

  cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (bus.cmd_data),
    .pop   (launch),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // rdy_q keeps cmd_ready low through reset and for the cycle until the first edge after it.
  assign bus.cmd_ready = rdy_q && !fifo_full;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign launch        = !fifo_empty && !cycle_active &&
                         ((state_q == ST_IDLE) || (state_q == ST_HOLD));
  assign drv_sel_n     = ~(NUM_OF_DRIVERS'(1) << idx_q);
  assign unused_bits   = ^{head.rsvd, head.addr};

  assign busy                = (fifo_count != '0) || (state_q != ST_IDLE);
  assign illegal_cmd         = illegal_q;
  assign bus.mem_write_n     = mem_wr_n_q;
  assign bus.mem_dot_write_n = dot_wr_n_q;
  assign bus.mem_sel_write_n = sel_wr_n_q;
  assign bus.write_config_n  = cfg_wr_n_q;
  assign bus.wr_address      = addr_q;
  assign bus.wr_data         = data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b0;
      op_q       <= OP_NOP;
      idx_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      mem_wr_n_q <= '1;
      dot_wr_n_q <= '1;
      sel_wr_n_q <= '1;
      cfg_wr_n_q <= 1'b1;
      illegal_q  <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      mem_wr_n_q <= '1;
      dot_wr_n_q <= '1;
      sel_wr_n_q <= '1;
      cfg_wr_n_q <= 1'b1;
      if (err_clear) illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (launch) begin
            state_q <= ST_SETUP;
            op_q    <= head.op;
            idx_q   <= head.idx;
            addr_q  <= MEM_ADDRESS_LENGTH'(head.addr);
            data_q  <= head.data;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          state_q <= ST_STROBE;
          // Written after the clear above so a simultaneous set wins.
          if (cmd_illegal(op_q, idx_q, NUM_OF_DRIVERS)) begin
            illegal_q <= 1'b1;
          end else begin
            case (op_q)
              OP_MEM:    mem_wr_n_q <= drv_sel_n;
              OP_DOT:    dot_wr_n_q <= drv_sel_n;
              OP_SEL:    sel_wr_n_q <= drv_sel_n;
              OP_CONFIG: cfg_wr_n_q <= 1'b0;
              OP_MEM_BC: mem_wr_n_q <= '0;
              default:   ;
            endcase
          end
        end
        ST_STROBE: state_q <= ST_HOLD;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_write_scheduler.md
MEM_WRITE_SCHEDULER -- requirements
Module: mem_write_scheduler

Interface
REQ-001 SHALL have parameter NUM_OF_DRIVERS, default 16: number of dot drivers and the width of the per-driver strobe buses.
REQ-002 SHALL have parameter MEM_ADDRESS_LENGTH, default 6: width of the memory address.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two: depth of the command buffer.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: `clock  in  1  sole clock`; `reset  in  1  asynchronous active-high reset`.
REQ-005 SHALL have the following command input ports:
- `cmd_valid  in  1`: command word offered.
- `cmd_data  in  32`: command word.
- `cmd_ready  out  1`: buffer can accept a word.
REQ-006 SHALL have the following window inputs:
- `cycle_active  in  1`: the backend is firing; memories must not be written.
- `err_clear  in  1`: clears the sticky flag.
REQ-007 SHALL have the following strobe outputs, all active-low:
- `mem_write_n  out  NUM_OF_DRIVERS`
- `mem_dot_write_n  out  NUM_OF_DRIVERS`
- `mem_sel_write_n  out  NUM_OF_DRIVERS`
- `write_config_n  out  1`
REQ-008 SHALL have the following data outputs:
- `wr_address  out  MEM_ADDRESS_LENGTH`
- `wr_data  out  16`
- `busy  out  1`: FIFO non-empty or a write is in progress.
- `illegal_cmd  out  1`: sticky flag.

Function
REQ-009 SHALL decode the command word fields as follows:
- [31:28] opcode: 0 NOP, 1 MEM, 2 DOT, 3 SEL, 4 CONFIG, 5 MEM broadcast.
- [27:24] driver index.
- [23:18] address; bits above MEM_ADDRESS_LENGTH are ignored.
- [17:16] ignored.
- [15:0] data.
REQ-010 SHALL push cmd_data into the FIFO on any cycle where cmd_valid and cmd_ready are both 1.
REQ-011 SHALL drive cmd_ready = !full, so no push occurs while the FIFO is full, even when a pop happens in the same cycle.
REQ-012 SHALL implement the FSM states IDLE, SETUP, STROBE and HOLD.
REQ-013 SHALL transition from IDLE to SETUP, popping the head entry, when the FIFO is non-empty and cycle_active = 0.
- Otherwise it SHALL remain in IDLE.
REQ-014 SHALL, in SETUP, drive wr_address and wr_data from the popped word with all strobes high, then advance to STROBE.
REQ-015 SHALL, in STROBE, drive the selected strobe low for exactly one cycle, then advance to HOLD.
- MEM, DOT and SEL assert bit [driver index] of the respective bus.
- MEM broadcast asserts all bits of mem_write_n.
- CONFIG asserts write_config_n and ignores the driver index.
REQ-016 SHALL, in HOLD, keep wr_address and wr_data stable with strobes high.
- It SHALL go directly to SETUP, popping the next entry, if the FIFO is non-empty and cycle_active = 0; otherwise to IDLE.
- Sustained throughput SHALL therefore be one write per 3 cycles.
REQ-017 SHALL sample cycle_active only at the IDLE and HOLD decisions; a write already in SETUP or STROBE SHALL complete even if cycle_active rises.
REQ-018 SHALL pop NOP entries, opcodes 6-15, and driver index >= NUM_OF_DRIVERS (for MEM, DOT and SEL) in SETUP with no strobe asserted. STROBE and HOLD still elapse.
REQ-019 SHALL set illegal_cmd in the cycle after an opcode 6-15 or out-of-range-index entry is in SETUP, and hold it until err_clear = 1.
- If a set and err_clear occur in the same cycle, the set wins.
REQ-020 SHALL give first-word latency from an accepting cycle T (FIFO empty, FSM in IDLE, cycle_active = 0) as: SETUP at T+1, strobe low at T+2, IDLE or next SETUP at T+4.
REQ-021 SHALL handle FIFO pointer wrap-around modulo FIFO_DEPTH and use a count of width log2(FIFO_DEPTH)+1.
REQ-022 SHALL permit a push and a pop in the same cycle when the FIFO is neither full nor empty, leaving the count unchanged.

Reset
REQ-023 SHALL, on reset assertion, immediately do all of the following:
- Force all strobes to 1.
- Clear wr_address, wr_data, busy and illegal_cmd to 0, and cmd_ready to 0.
- Return the FSM to IDLE and empty the FIFO.
REQ-024 SHALL abort a write that is in STROBE when reset asserts, with the strobe deasserted asynchronously.
REQ-025 SHALL drive cmd_ready = 1 from the first clock edge after reset deasserts.

Structure
REQ-026 SHALL place the opcode constants and the FSM state encoding in the shared package sequencer_pkg.
REQ-027 SHALL implement the buffer as the sub-module cmd_fifo (parameterised on width and depth, with push, pop, full, empty and count).

Verification
REQ-028 SHALL cover the directed test "Single write": push 0x1_3_14_00AB (driver 3, address 5) with cycle_active = 0.
- Required: mem_write_n = 0xFFF7 for exactly one cycle at T+2.
- Required: wr_address = 5 and wr_data = 0x00AB from T+1 to T+3.
REQ-029 SHALL cover the directed test "Deferral": hold cycle_active = 1 and push 4 words.
- Required: cmd_ready = 0 after the 4th push, with no strobe asserted.
- Required: after cycle_active falls, strobes at 3-cycle spacing, in order.
REQ-030 SHALL cover the directed test "Window close mid-write": raise cycle_active in the STROBE cycle.
- Required: the write completes, and the next queued write waits until cycle_active = 0.
REQ-031 SHALL cover the directed test "Broadcast and config": push opcode 5 and then opcode 4.
- Required: mem_write_n = 0x0000 for one cycle, then write_config_n = 0 for one cycle.
REQ-032 SHALL cover the directed test "Illegal": push opcode 7, then opcode 1 with driver index 15 when NUM_OF_DRIVERS = 8.
- Required: no strobe is asserted and illegal_cmd = 1 until err_clear.
REQ-033 SHALL cover the directed test "Reset mid-STROBE": assert reset.
- Required: the strobe goes high asynchronously, busy = 0, the FIFO is empty, and cmd_ready = 1 after release.
